mc_main_ctrl: RTL and testbench
===============================

// Module: mc_main_ctrl
// PURPOSE
//  Multicycle main-control FSM for the RV64I core. Sequences fetch/decode/execute/memory/writeback
//  for ld, sd, R-type ALU, I-type ALU and beq. Drives immgen (ImmSrc), ALU operand muxes, memory
//  and register-file enables. Waits on a memory ready handshake; flags illegal opcodes.
// PARAMETERS
//  MEM_HANDSHAKE  1  1: FETCH/MEMREAD/MEMWRITE hold until mem_ready=1; 0: mem_ready ignored (treated as 1)
//  ILLEGAL_TRAP   1  1: illegal opcode -> TRAP state (sticky); 0: illegal -> back to FETCH, pulse illegal
// PORTS
//  clk         in   1  clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  opcode      in   7  instr[6:0] from IR (valid from DECODE on)
//  funct3      in   3  instr[14:12]
//  zero        in   1  ALU zero flag (valid in BEQ)
//  mem_ready   in   1  memory access complete this cycle
//  ImmSrc      out  2  to immgen: 00 I, 01 S, 10 B
//  ALUSrcA     out  2  00 PC, 01 OldPC, 10 rs1 reg
//  ALUSrcB     out  2  00 rs2 reg, 01 ImmExt, 10 const 4
//  ALUOp       out  2  00 add, 01 sub, 10 funct-decode
//  ResultSrc   out  2  00 ALUOut, 01 mem Data, 10 ALUResult
//  AdrSrc      out  1  0 PC, 1 ALUOut
//  IRWrite     out  1  latch IR/OldPC
//  PCWrite     out  1  PCUpdate | (Branch & zero)
//  RegWrite    out  1  register-file write enable
//  MemWrite    out  1  data memory write enable
//  mem_req     out  1  memory access in progress
//  illegal     out  1  illegal-opcode flag
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=FETCH; every enable (IRWrite, PCWrite, RegWrite, MemWrite, mem_req,
//    illegal) forced 0 while rst_n=0; mux selects 00. Reset mid-instruction aborts it, no writes.
//  - Moore outputs decoded from state; PCWrite combinational on zero in BEQ only.
//  - States/transitions:
//    FETCH:  AdrSrc=0, mem_req=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; when mem_ready:
//            IRWrite=1, PCWrite=1 (PC<=PC+4), -> DECODE; else hold, IRWrite/PCWrite=0.
//    DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, ImmSrc=10 (branch target precompute). Dispatch:
//            0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; else ILLEGAL.
//    MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ImmSrc=00 (ld) / 01 (sd); -> MEMREAD (ld) / MEMWRITE (sd).
//    MEMREAD: AdrSrc=1, ResultSrc=00, mem_req=1; -> MEMWB on mem_ready, else hold.
//    MEMWB:  ResultSrc=01, RegWrite=1; -> FETCH.
//    MEMWRITE: AdrSrc=1, ResultSrc=00, mem_req=1; MemWrite=1 only in the mem_ready cycle; -> FETCH.
//    EXECR:  ALUSrcA=10, ALUSrcB=00, ALUOp=10; -> ALUWB.
//    EXECI:  ALUSrcA=10, ALUSrcB=01, ALUOp=10, ImmSrc=00; -> ALUWB.
//    ALUWB:  ResultSrc=00, RegWrite=1; -> FETCH.
//    BEQ:    ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, ImmSrc=10, Branch=1; PCWrite=zero; -> FETCH.
//    ILLEGAL: no enables; illegal=1 for one cycle; -> FETCH if ILLEGAL_TRAP=0, else -> TRAP.
//    TRAP:   illegal=1 held, no enables, stays until reset.
//  - funct3 checked only for opcode 0000011/0100011/1100011: must be 011/011/000, else ILLEGAL.
//  - Latency (mem_ready=1 always): ld 5 cycles, sd 4, R/I-type 4, beq 3. Each mem_ready=0 cycle adds 1.
//  - Exactly one RegWrite or MemWrite pulse per retired ld/sd/ALU instr; none for beq/illegal.
//  - ImmSrc=11 never driven. Unused state encodings -> FETCH next cycle, no enables.
// TESTING
//  1. addi 0x00500093, mem_ready=1: FETCH,DECODE,EXECI,ALUWB; ImmSrc=00 in EXECI; one RegWrite pulse.
//  2. ld 0x0080B103, mem_ready low 2 cycles in MEMREAD: 7 cycles total, RegWrite only in MEMWB.
//  3. sd 0x0020B823: ImmSrc=01 in MEMADR, MemWrite=1 exactly 1 cycle, RegWrite never.
//  4. beq 0x00208463 with zero=1 then zero=0: PCWrite in BEQ =1 / =0; 3 cycles each.
//  5. add 0x002081B3 then 0xFFFFFFFF: add retires; illegal=1, ILLEGAL_TRAP=1 -> stuck in TRAP, no enables.
//  6. rst_n low during MEMWRITE: MemWrite drops immediately, state FETCH after release.

Source files
------------

// File: rtl/mc_main_ctrl.sv
// Multicycle main-control FSM for the RV64I core: sequences fetch/decode/execute/memory/writeback
// for ld, sd, R-type, I-type and beq, with a memory-ready handshake and illegal-opcode flagging.
//
// state    | meaning
// ---------+----------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE   | precompute branch target, dispatch on opcode/funct3
// MEMADR   | rs1 + imm address for ld/sd
// MEMREAD  | data read in progress
// MEMWB    | write loaded data to register file
// MEMWRITE | data write in progress
// EXECR    | R-type ALU operation
// EXECI    | I-type ALU operation
// ALUWB    | write ALU result to register file
// BEQ      | compare rs1/rs2, take branch on zero
// ILLEGAL  | one-cycle illegal-opcode flag
// TRAP     | sticky illegal state, left only through reset
module mc_main_ctrl #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ILLEGAL_TRAP  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       mem_req,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_ILLEGAL  = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_RALU = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_e state_q, state_d;

  logic       ready;
  logic [1:0] imm_src_c, alu_src_a_c, alu_src_b_c, alu_op_c, result_src_c;
  logic       adr_src_c, ir_write_c, pc_write_c, reg_write_c, mem_write_c, mem_req_c, illegal_c;

  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = S_FETCH;
    imm_src_c    = 2'b00;
    alu_src_a_c  = 2'b00;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    result_src_c = 2'b00;
    adr_src_c    = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    mem_write_c  = 1'b0;
    mem_req_c    = 1'b0;
    illegal_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        ir_write_c   = ready;
        pc_write_c   = ready;
        state_d      = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
        imm_src_c   = 2'b10;
        case (opcode)
          OP_LD, OP_SD: state_d = (funct3 == 3'b011) ? S_MEMADR : S_ILLEGAL;
          OP_RALU:      state_d = S_EXECR;
          OP_IALU:      state_d = S_EXECI;
          OP_BEQ:       state_d = (funct3 == 3'b000) ? S_BEQ : S_ILLEGAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        // opcode bit 5 separates sd (S-format immediate) from ld
        imm_src_c   = opcode[5] ? 2'b01 : 2'b00;
        state_d     = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src_c = 1'b1;
        mem_req_c = 1'b1;
        state_d   = ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_c   = 1'b1;
        mem_req_c   = 1'b1;
        mem_write_c = ready;
        state_d     = ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        alu_op_c    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: reg_write_c = 1'b1;
      S_BEQ: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = 2'b01;
        imm_src_c   = 2'b10;
        pc_write_c  = zero;
      end
      S_ILLEGAL: begin
        illegal_c = 1'b1;
        state_d   = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
      end
      S_TRAP: begin
        illegal_c = 1'b1;
        state_d   = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs are gated by rst_n so nothing is asserted while reset is held.
  assign ImmSrc    = rst_n ? imm_src_c    : 2'b00;
  assign ALUSrcA   = rst_n ? alu_src_a_c  : 2'b00;
  assign ALUSrcB   = rst_n ? alu_src_b_c  : 2'b00;
  assign ALUOp     = rst_n ? alu_op_c     : 2'b00;
  assign ResultSrc = rst_n ? result_src_c : 2'b00;
  assign AdrSrc    = rst_n & adr_src_c;
  assign IRWrite   = rst_n & ir_write_c;
  assign PCWrite   = rst_n & pc_write_c;
  assign RegWrite  = rst_n & reg_write_c;
  assign MemWrite  = rst_n & mem_write_c;
  assign mem_req   = rst_n & mem_req_c;
  assign illegal   = rst_n & illegal_c;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl: each cycle's expected control word is queued when the
// inputs are driven, then popped and compared against the DUT outputs mid-cycle.
module tb_mc_main_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, mem_req, illegal;

  int checks = 0;
  int errors = 0;

  typedef enum int {T_RST, T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
                    T_EXECR, T_EXECI, T_ALUWB, T_BEQ, T_ILLEGAL, T_TRAP} tst_e;

  typedef struct {
    string       tag;
    logic [16:0] exp;
    logic [16:0] mask;
  } sb_item_t;

  sb_item_t sb_q[$];

  mc_main_ctrl #(.MEM_HANDSHAKE(1'b1), .ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .mem_req(mem_req),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Packed word: ImmSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, AdrSrc, IRWrite, PCWrite,
  // RegWrite, MemWrite, mem_req, illegal. Mask bits cover only fields the state defines;
  // enables are always checked.
  function automatic void expect_state(input tst_e s, input logic mr, input logic z,
                                       input logic [6:0] opc, input string tag);
    logic [1:0] imm, sa, sb, op, res;
    logic       adr, irw, pcw, rw, mw, mq, il;
    logic       m_imm, m_sa, m_sb, m_op, m_res, m_adr;
    sb_item_t   it;
    {imm, sa, sb, op, res} = '0;
    {adr, irw, pcw, rw, mw, mq, il} = '0;
    {m_imm, m_sa, m_sb, m_op, m_res, m_adr} = '0;
    case (s)
      T_RST:      {m_imm, m_sa, m_sb, m_op, m_res, m_adr} = '1;
      T_FETCH: begin
        sa = 2'b00; sb = 2'b10; op = 2'b00; res = 2'b10; adr = 1'b0; mq = 1'b1;
        irw = mr; pcw = mr;
        {m_sa, m_sb, m_op, m_res, m_adr} = '1;
      end
      T_DECODE: begin
        sa = 2'b01; sb = 2'b01; op = 2'b00; imm = 2'b10;
        {m_sa, m_sb, m_op, m_imm} = '1;
      end
      T_MEMADR: begin
        sa = 2'b10; sb = 2'b01; op = 2'b00;
        imm = (opc == 7'b0100011) ? 2'b01 : 2'b00;
        {m_sa, m_sb, m_op, m_imm} = '1;
      end
      T_MEMREAD: begin
        adr = 1'b1; res = 2'b00; mq = 1'b1;
        {m_adr, m_res} = '1;
      end
      T_MEMWB: begin
        res = 2'b01; rw = 1'b1; m_res = 1'b1;
      end
      T_MEMWRITE: begin
        adr = 1'b1; res = 2'b00; mq = 1'b1; mw = mr;
        {m_adr, m_res} = '1;
      end
      T_EXECR: begin
        sa = 2'b10; sb = 2'b00; op = 2'b10;
        {m_sa, m_sb, m_op} = '1;
      end
      T_EXECI: begin
        sa = 2'b10; sb = 2'b01; op = 2'b10; imm = 2'b00;
        {m_sa, m_sb, m_op, m_imm} = '1;
      end
      T_ALUWB: begin
        res = 2'b00; rw = 1'b1; m_res = 1'b1;
      end
      T_BEQ: begin
        sa = 2'b10; sb = 2'b00; op = 2'b01; res = 2'b00; imm = 2'b10; pcw = z;
        {m_sa, m_sb, m_op, m_res, m_imm} = '1;
      end
      T_ILLEGAL, T_TRAP: il = 1'b1;
      default: ;
    endcase
    it.tag  = tag;
    it.mask = {{2{m_imm}}, {2{m_sa}}, {2{m_sb}}, {2{m_op}}, {2{m_res}}, m_adr, 6'h3F};
    it.exp  = {imm, sa, sb, op, res, adr, irw, pcw, rw, mw, mq, il} & it.mask;
    sb_q.push_back(it);
  endfunction

  task automatic pop_check();
    sb_item_t    it;
    logic [16:0] obs;
    obs = {ImmSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, AdrSrc, IRWrite, PCWrite,
           RegWrite, MemWrite, mem_req, illegal};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=<queued item>", obs);
    end else begin
      it = sb_q.pop_front();
      assert ((obs & it.mask) === it.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h (mask %h)", it.tag, obs & it.mask, it.exp, it.mask);
      end
    end
  endtask

  // Called at posedge+1: drive inputs, queue expectation, compare at negedge, advance.
  task automatic step(input tst_e s, input logic mr, input logic z, input string tag);
    mem_ready = mr;
    zero      = z;
    expect_state(s, mr, z, opcode, tag);
    @(negedge clk);
    pop_check();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    #1;
    expect_state(T_RST, 1'b0, 1'b0, opcode, {tag, "_async"});
    pop_check();
    @(posedge clk);
    #1;
    expect_state(T_RST, 1'b0, 1'b0, opcode, {tag, "_held"});
    pop_check();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] instr);
    opcode = instr[6:0];
    funct3 = instr[14:12];
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; funct3 = '0; zero = 1'b0; mem_ready = 1'b0;
    do_reset("reset");

    // addi x1, x0, 5
    set_instr(32'h00500093);
    step(T_FETCH, 1'b1, 1'b0, "addi_fetch");
    step(T_DECODE, 1'b1, 1'b0, "addi_decode");
    step(T_EXECI, 1'b1, 1'b0, "addi_execi");
    step(T_ALUWB, 1'b1, 1'b0, "addi_aluwb");

    // ld with two wait cycles in MEMREAD: seven cycles total
    set_instr(32'h0080B103);
    step(T_FETCH, 1'b1, 1'b0, "ld_fetch");
    step(T_DECODE, 1'b1, 1'b0, "ld_decode");
    step(T_MEMADR, 1'b1, 1'b0, "ld_memadr");
    step(T_MEMREAD, 1'b0, 1'b0, "ld_memread_wait0");
    step(T_MEMREAD, 1'b0, 1'b0, "ld_memread_wait1");
    step(T_MEMREAD, 1'b1, 1'b0, "ld_memread_ready");
    step(T_MEMWB, 1'b1, 1'b0, "ld_memwb");

    // sd
    set_instr(32'h0020B823);
    step(T_FETCH, 1'b1, 1'b0, "sd_fetch");
    step(T_DECODE, 1'b1, 1'b0, "sd_decode");
    step(T_MEMADR, 1'b1, 1'b0, "sd_memadr");
    step(T_MEMWRITE, 1'b1, 1'b0, "sd_memwrite");

    // beq taken, then not taken with a fetch stall
    set_instr(32'h00208463);
    step(T_FETCH, 1'b1, 1'b0, "beq1_fetch");
    step(T_DECODE, 1'b1, 1'b0, "beq1_decode");
    step(T_BEQ, 1'b1, 1'b1, "beq1_taken");
    step(T_FETCH, 1'b0, 1'b0, "beq0_fetch_stall");
    step(T_FETCH, 1'b1, 1'b0, "beq0_fetch");
    step(T_DECODE, 1'b1, 1'b0, "beq0_decode");
    step(T_BEQ, 1'b1, 1'b0, "beq0_not_taken");

    // add, then illegal word -> sticky trap
    set_instr(32'h002081B3);
    step(T_FETCH, 1'b1, 1'b0, "add_fetch");
    step(T_DECODE, 1'b1, 1'b0, "add_decode");
    step(T_EXECR, 1'b1, 1'b0, "add_execr");
    step(T_ALUWB, 1'b1, 1'b0, "add_aluwb");
    set_instr(32'hFFFFFFFF);
    step(T_FETCH, 1'b1, 1'b0, "ill_fetch");
    step(T_DECODE, 1'b1, 1'b0, "ill_decode");
    step(T_ILLEGAL, 1'b1, 1'b0, "ill_illegal");
    set_instr(32'h00500093);
    step(T_TRAP, 1'b1, 1'b0, "ill_trap0");
    step(T_TRAP, 1'b1, 1'b1, "ill_trap1");
    step(T_TRAP, 1'b1, 1'b0, "ill_trap2");

    // reset out of TRAP, then reset in the middle of a MEMWRITE ready cycle
    do_reset("reset_from_trap");
    set_instr(32'h0020B823);
    step(T_FETCH, 1'b1, 1'b0, "sdr_fetch");
    step(T_DECODE, 1'b1, 1'b0, "sdr_decode");
    step(T_MEMADR, 1'b1, 1'b0, "sdr_memadr");
    step(T_MEMWRITE, 1'b0, 1'b0, "sdr_memwrite_wait");
    mem_ready = 1'b1;
    #1;
    expect_state(T_MEMWRITE, 1'b1, 1'b0, opcode, "sdr_memwrite_ready");
    pop_check();
    do_reset("reset_mid_memwrite");
    step(T_FETCH, 1'b1, 1'b0, "post_reset_fetch");

    // ld with a wrong funct3 is illegal
    funct3 = 3'b000;
    opcode = 7'b0000011;
    step(T_DECODE, 1'b1, 1'b0, "badld_decode");
    step(T_ILLEGAL, 1'b1, 1'b0, "badld_illegal");
    step(T_TRAP, 1'b1, 1'b0, "badld_trap");

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
